clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable clock divider and tick generator; the next generation of the fixed-ratio divider chain.
- Runs entirely in the `clk` domain and produces no derived clocks.
- Outputs a one-cycle `tick` strobe every N cycles, plus a registered divided square wave `clk_out`.
- Serves the DDS sample-rate, display-scan and LED-blink paths from one parametrised block; the divisor can be changed on the fly without glitches.

Parameters:
- WIDTH, 32, bit width of the counter and divisor.
- DEFAULT_DIV, 100000, active divisor after reset (100 MHz -> 1 kHz). Must be 1..2^WIDTH-1.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable.
- clr  in  1  synchronous restart of the period.
- div_in  in  WIDTH  new divisor value.
- div_load  in  1  one-cycle strobe that captures `div_in`.
- tick  out  1  one-cycle strobe, once per period.
- clk_out  out  1  divided square wave, registered.
- load_pending  out  1  a captured divisor is waiting for the period boundary.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, N_act=DEFAULT_DIV, pending=0, load_pending=0.
  - tick=0, clk_out=0.
- Divisor sanitising: a written divisor of 0 is stored as 1.
- High time: H = (N_act+1)>>1, i.e. ceil(N/2).
- Enabled edge (en=1, clr=0):
  - If cnt==N_act-1 (wrap): cnt<=0, tick<=1. If a load is pending, N_act<=pending and load_pending<=0.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - clk_out <= (cnt_next < H_next), where H_next is computed from the N_act in force after the edge.
- en=0: cnt, N_act and clk_out hold; tick<=0; loads are still captured.
- Latency: counting from reset or clr, the first tick is registered on the Nth enabled edge, then every N enabled edges. The tick is high for exactly one clk cycle.
- N=1: tick and clk_out are held at 1 on every enabled edge.
- div_load:
  - Captures the sanitised div_in into pending and sets load_pending.
  - Back-to-back loads: the last one wins.
  - Load in the same cycle as a wrap: div_in is applied directly at that wrap and load_pending stays 0.
- clr=1 (overrides en):
  - cnt<=0, tick<=0, clk_out<=0.
  - A pending divisor is applied immediately.
  - If div_load is asserted in the same cycle, that div_in is applied.
- Priority: rst > clr > wrap/count. div_load is captured in parallel with all of these.
- No glitches: N_act changes only at a wrap or a clr. A period in progress always completes with its old divisor.
- Arithmetic: all compares are unsigned, WIDTH bits. cnt never exceeds N_act-1.

Optional Feature:
- Macro: CLK_DIV_DUTY_EN.
- When defined:
  - Adds input duty_in [WIDTH], captured together with div_in on div_load into a pending/active pair.
  - H = min(duty_act, N_act).
  - duty=0 gives clk_out constant 0; duty>=N gives clk_out constant 1.
  - Reset duty_act = (DEFAULT_DIV+1)>>1.
- When not defined: the duty_in port is absent and H = ceil(N_act/2).
- tick behaviour is identical in both builds.

Test Plan:
- Reset release with DEFAULT_DIV=4 and en=1 -> tick pulses on edges 4, 8, 12 (one cycle each); clk_out pattern per period is 1,1,0,0 after the first wrap.
- div_in=10 with div_load mid-period, current N=4 -> load_pending=1 until the wrap; the next tick arrives 10 edges later and load_pending=0.
- div_load at the same cycle as a wrap with div_in=3 -> the following period is 3 cycles and load_pending is never asserted.
- div_in=0 loaded -> behaves as N=1: tick=1 on every enabled edge and clk_out=1.
- en low for 5 cycles mid-period with N=6 -> cnt holds, no tick; the tick arrives 5 cycles later than the nominal edge.
- clr pulsed mid-period with pending=7 -> cnt=0, clk_out=0; the next tick after 7 edges. Assert rst mid-period -> outputs go 0 immediately without waiting for a clk edge.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: one-cycle tick every N enabled cycles plus a registered
// divided square wave. Define CLK_DIV_DUTY_EN to add a programmable high time (duty_in).
module clk_div_prog #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] div_in,
`ifdef CLK_DIV_DUTY_EN
   input  logic [WIDTH-1:0] duty_in,
`endif
   input  logic             div_load,
   output logic             tick,
   output logic             clk_out,
   output logic             load_pending
);

   localparam logic [WIDTH-1:0] DivReset = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] One      = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] n_act_q, n_act_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             lp_q, lp_d;
   logic             tick_q, tick_d;
   logic             clk_out_q, clk_out_d;

   logic [WIDTH-1:0] div_s;
   logic             wrap;
   logic             apply;
   logic [WIDTH:0]   h_next;

`ifdef CLK_DIV_DUTY_EN
   // Reset high time is ceil(DEFAULT_DIV/2), written to avoid 32-bit overflow of DEFAULT_DIV+1.
   localparam logic [WIDTH-1:0] DutyReset = WIDTH'((DEFAULT_DIV >> 1) + (DEFAULT_DIV & 1));
   logic [WIDTH-1:0] duty_act_q, duty_act_d;
   logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
`endif

   always_comb begin
      div_s     = (div_in == '0) ? One : div_in;
      wrap      = (cnt_q == n_act_q - One);
      cnt_d     = cnt_q;
      n_act_d   = n_act_q;
      pend_d    = pend_q;
      lp_d      = lp_q;
      tick_d    = 1'b0;
      clk_out_d = clk_out_q;
      apply     = 1'b0;
`ifdef CLK_DIV_DUTY_EN
      duty_act_d  = duty_act_q;
      duty_pend_d = duty_pend_q;
`endif

      if (div_load) begin
         pend_d = div_s;
         lp_d   = 1'b1;
`ifdef CLK_DIV_DUTY_EN
         duty_pend_d = duty_in;
`endif
      end

      if (clr) begin
         cnt_d = '0;
         apply = 1'b1;
      end else if (en) begin
         if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            apply  = 1'b1;
         end else begin
            cnt_d = cnt_q + One;
         end
      end

      // The divisor only changes at a period boundary; a same-cycle load bypasses pending.
      if (apply) begin
         lp_d = 1'b0;
         if (div_load) begin
            n_act_d = div_s;
`ifdef CLK_DIV_DUTY_EN
            duty_act_d = duty_in;
`endif
         end else if (lp_q) begin
            n_act_d = pend_q;
`ifdef CLK_DIV_DUTY_EN
            duty_act_d = duty_pend_q;
`endif
         end
      end

`ifdef CLK_DIV_DUTY_EN
      h_next = (duty_act_d < n_act_d) ? {1'b0, duty_act_d} : {1'b0, n_act_d};
`else
      h_next = ({1'b0, n_act_d} + (WIDTH+1)'(1)) >> 1;
`endif

      if (clr) begin
         clk_out_d = 1'b0;
      end else if (en) begin
         clk_out_d = ({1'b0, cnt_d} < h_next);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         n_act_q   <= DivReset;
         pend_q    <= '0;
         lp_q      <= 1'b0;
         tick_q    <= 1'b0;
         clk_out_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         n_act_q   <= n_act_d;
         pend_q    <= pend_d;
         lp_q      <= lp_d;
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
      end
   end

`ifdef CLK_DIV_DUTY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_act_q  <= DutyReset;
         duty_pend_q <= '0;
      end else begin
         duty_act_q  <= duty_act_d;
         duty_pend_q <= duty_pend_d;
      end
   end
`endif

   assign tick         = tick_q;
   assign clk_out      = clk_out_q;
   assign load_pending = lp_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (WIDTH=8, DEFAULT_DIV=4).
module tb_clk_div_prog;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic             clr = 1'b0;
   logic [WIDTH-1:0] div_in = '0;
   logic             div_load = 1'b0;
   logic             tick;
   logic             clk_out;
   logic             load_pending;

   int errors = 0;
   int checks = 0;

`ifdef CLK_DIV_DUTY_EN
   // Keeps the duty build equivalent to ceil(N/2) so the same expectations apply.
   logic [WIDTH:0]   duty_wide;
   logic [WIDTH-1:0] duty_in;
   assign duty_wide = ({1'b0, div_in} + (WIDTH+1)'(1)) >> 1;
   assign duty_in   = (div_in == '0) ? WIDTH'(1) : duty_wide[WIDTH-1:0];
`endif

   clk_div_prog #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .clr          (clr),
      .div_in       (div_in),
`ifdef CLK_DIV_DUTY_EN
      .duty_in      (duty_in),
`endif
      .div_load     (div_load),
      .tick         (tick),
      .clk_out      (clk_out),
      .load_pending (load_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts enabled edges up to and including the next tick.
   task automatic wait_tick(input int limit, output int n, output bit saw_lp);
      bit got;
      n      = 0;
      saw_lp = 1'b0;
      got    = 1'b0;
      for (int i = 0; i < limit; i++) begin
         step();
         n++;
         if (load_pending) saw_lp = 1'b1;
         if (tick) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("tick_timeout", 32'(got), 32'd1);
   endtask

   initial begin
      int n;
      bit saw;

      // Reset state
      #1 rst = 1'b1;
      #1;
      check("rst_tick", 32'(tick), 0);
      check("rst_clk_out", 32'(clk_out), 0);
      check("rst_lp", 32'(load_pending), 0);
      step();
      rst = 1'b0;
      en  = 1'b1;

      // DEFAULT_DIV=4: tick on edges 4,8,12; clk_out high while cnt<2
      for (int e = 1; e <= 12; e++) begin
         step();
         check($sformatf("n4_tick_e%0d", e), 32'(tick), 32'((e % 4) == 0));
         check($sformatf("n4_clk_e%0d", e), 32'(clk_out), 32'((e % 4) < 2));
      end

      // Load 10 mid-period: pending until wrap, then 10-edge period
      step();
      step();
      div_in   = 8'd10;
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      check("ld10_pending", 32'(load_pending), 1);
      check("ld10_no_tick", 32'(tick), 0);
      step();
      check("ld10_wrap_tick", 32'(tick), 1);
      check("ld10_lp_clear", 32'(load_pending), 0);
      check("ld10_clk_hi", 32'(clk_out), 1);
      wait_tick(40, n, saw);
      check("n10_period", 32'(n), 10);

      // Load 3 in the wrap cycle: applied directly, never pending
      for (int i = 0; i < 9; i++) step();
      div_in   = 8'd3;
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      check("ld3_wrap_tick", 32'(tick), 1);
      check("ld3_lp", 32'(load_pending), 0);
      wait_tick(40, n, saw);
      check("n3_period", 32'(n), 3);
      check("n3_never_pending", 32'(saw), 0);

      // Load 0 -> sanitised to 1
      div_in   = 8'd0;
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      wait_tick(40, n, saw);
      check("ld0_rest_of_n3", 32'(n), 2);
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("n1_tick_%0d", i), 32'(tick), 1);
         check($sformatf("n1_clk_%0d", i), 32'(clk_out), 1);
      end

      // N=6, en low for 5 cycles at cnt=2
      div_in   = 8'd6;
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      check("ld6_tick", 32'(tick), 1);
      step();
      step();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("en0_tick_%0d", i), 32'(tick), 0);
         check($sformatf("en0_clk_hold_%0d", i), 32'(clk_out), 1);
      end
      en = 1'b1;
      wait_tick(40, n, saw);
      check("en0_delayed", 32'(n), 4);

      // clr with pending=7
      step();
      step();
      div_in   = 8'd7;
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      check("clr_pending_set", 32'(load_pending), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_tick", 32'(tick), 0);
      check("clr_clk_out", 32'(clk_out), 0);
      check("clr_lp", 32'(load_pending), 0);
      wait_tick(40, n, saw);
      check("clr_n7_period", 32'(n), 7);

      // Async reset right after a tick: outputs drop without a clock edge
      check("pre_rst_tick", 32'(tick), 1);
      check("pre_rst_clk", 32'(clk_out), 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_tick", 32'(tick), 0);
      check("async_rst_clk", 32'(clk_out), 0);
      #1 rst = 1'b0;
      wait_tick(40, n, saw);
      check("post_rst_default", 32'(n), 4);

      // Back-to-back loads: last wins
      div_in   = 8'd5;
      div_load = 1'b1;
      step();
      div_in = 8'd2;
      step();
      div_load = 1'b0;
      wait_tick(40, n, saw);
      check("b2b_rest_of_n4", 32'(n), 2);
      wait_tick(40, n, saw);
      check("b2b_last_wins", 32'(n), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
